pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined integer add/subtract unit for the MIPS datapath. It is the registered successor to the single-cycle 32-bit combinational adder. Operands are split into equal slices, one slice per pipeline stage, with the carry rippling stage to stage. It adds carry-out, signed-overflow and subtract support, plus a valid/ready handshake with back-pressure, so it can feed the ALU result bus or a multi-cycle multiply/divide sequencer.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; slice width SEG = WIDTH/STAGES; STAGES ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  1  operand set present.
- in_ready  output  1  unit accepts the operand set this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0: A+B; 1: A−B.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_carry  output  1  carry out of the MSB; for subtract, 1 = no borrow (A ≥ B unsigned).
- out_ovf  output  1  two's-complement signed overflow.

## Operation
- Subtract: B is inverted at the input and carry-in is 1; add uses carry-in 0.
- Stage k (0..STAGES−1) adds slice k of A and B′ plus the carry registered by stage k−1. It registers the SEG-bit partial sum, the carry, the still-unused upper slices of A and B′, the lower partial sums already produced, and a valid bit.
- Final stage computes:
  - out_carry = carry out of bit WIDTH−1.
  - out_ovf = (A[msb] == B′[msb]) & (sum[msb] != A[msb]), using the delayed A/B′ MSBs.
- Pipeline advance: adv = ~out_valid | out_ready. When adv = 1, every stage loads from its predecessor and stage 0 loads {in_valid, operands}. When adv = 0, all stages hold.
- in_ready = adv. An operand set is accepted when in_valid & in_ready.
- Bubbles are not compressed: an empty middle stage still moves only on adv.
- Results leave in issue order. No reordering, no dropping, no duplication.

## Timing
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall. A set accepted at edge n appears after edge n+STAGES−1, i.e. valid during cycle n+STAGES.
- Throughput: one result per cycle while out_ready = 1.
- Stall: out_valid & ~out_ready holds out_sum, out_carry and out_ovf stable and deasserts in_ready in the same cycle (combinational path out_ready → in_ready).
- Reset: with rst_n = 0 at an edge, all valid bits, data, carries and outputs clear to 0. out_valid = 0, out_sum = 0, out_carry = 0, out_ovf = 0. in_ready = 1 after reset.
- Reset mid-operation discards all in-flight sets; no result emerges for them.
- Simultaneous in_valid with out_valid & out_ready: the output retires and the new set enters in the same edge.
- Input accepted while in_ready = 0 is ignored; the upstream source must hold its operands.
- STAGES = 1 degenerates to one registered full-width adder with the same handshake.

## Structure
- Package adder_pkg holds:
  - the op encoding constants (OP_ADD = 1'b0, OP_SUB = 1'b1);
  - a function seg_width(WIDTH, STAGES);
  - an elaboration check that WIDTH % STAGES == 0.
- Sub-module adder_slice: one SEG-bit combinational add with carry-in and carry-out, instantiated STAGES times via generate.
- The pipeline registers and handshake logic live in pipelined_adder.

## Test plan
All scenarios use WIDTH = 32 and STAGES = 4.
1. Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 → out_valid = 0 and out_sum = 0 throughout; in_ready = 1 after release.
2. Add with carry: A = 0xFFFF_FFFF, B = 0x0000_0001, sub = 0 → 4 cycles later sum = 0x0000_0000, carry = 1, ovf = 0. Also A = 0x7FFF_FFFF, B = 1 → sum = 0x8000_0000, carry = 0, ovf = 1.
3. Subtract: A = 5, B = 7, sub = 1 → sum = 0xFFFF_FFFE, carry = 0 (borrow), ovf = 0. Also A = 0x8000_0000, B = 1 → sum = 0x7FFF_FFFF, carry = 1, ovf = 1.
4. Streaming: 100 back-to-back random sets with out_ready = 1 → one result per cycle, in order, all matching the reference model, first result exactly 4 cycles after the first acceptance.
5. Back-pressure: random out_ready (50%) with random in_valid → no lost or duplicated results, outputs stable while stalled, and in_ready = 0 exactly when out_valid & ~out_ready.
6. Mid-flight reset: issue 3 sets, assert rst_n = 0 for 1 cycle → no result for those sets appears; the next set issued completes correctly.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: op encoding and
// helpers that derive and validate the per-stage slice width.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  // True when the operand width divides evenly into the requested stages.
  function automatic bit split_ok(input int width, input int stages);
    return (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// One SEG-bit combinational adder slice with carry-in and carry-out.
module adder_slice #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one SEG-bit slice per stage with the carry rippling
// stage to stage, and a single global advance signal for back-pressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int SEG  = seg_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (!split_ok(WIDTH, STAGES)) begin : g_bad_split
    $error("pipelined_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    b_eff = in_b;
    cin   = 1'b0;
    case (in_sub)
      OP_ADD:  ;
      OP_SUB: begin
        b_eff = ~in_b;
        cin   = 1'b1;
      end
      default: ;
    endcase
  end

  // The whole pipe moves together; a stalled output freezes every stage.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:k*SEG]   a_src, b_src;
    logic                   c_src, v_src;
    logic [SEG-1:0]         s_seg;
    logic                   c_seg;
    logic                   v_q, c_q;
    logic [(k+1)*SEG-1:0]   sum_q;

    if (k == 0) begin : g_in
      assign a_src = in_a;
      assign b_src = b_eff;
      assign c_src = cin;
      assign v_src = in_valid;

      // NOTE: pipeline data is reset too, so the outputs read 0 after reset.
      always_ff @(posedge clk) begin
        if (!rst_n)   sum_q <= '0;
        else if (adv) sum_q <= s_seg;
      end
    end else begin : g_in
      assign a_src = g_stage[k-1].g_fwd.a_hi_q;
      assign b_src = g_stage[k-1].g_fwd.b_hi_q;
      assign c_src = g_stage[k-1].c_q;
      assign v_src = g_stage[k-1].v_q;

      always_ff @(posedge clk) begin
        if (!rst_n)   sum_q <= '0;
        else if (adv) sum_q <= {s_seg, g_stage[k-1].sum_q};
      end
    end

    adder_slice #(.SEG(SEG)) u_slice (
      .a    (a_src[k*SEG +: SEG]),
      .b    (b_src[k*SEG +: SEG]),
      .cin  (c_src),
      .sum  (s_seg),
      .cout (c_seg)
    );

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_src;
        c_q <= c_seg;
      end
    end

    if (k < LAST) begin : g_fwd
      logic [WIDTH-1:(k+1)*SEG] a_hi_q, b_hi_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (adv) begin
          a_hi_q <= a_src[WIDTH-1:(k+1)*SEG];
          b_hi_q <= b_src[WIDTH-1:(k+1)*SEG];
        end
      end
    end else begin : g_last
      // Only the operand sign bits survive to the end, for overflow detection.
      logic a_msb_q, b_msb_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_msb_q <= 1'b0;
          b_msb_q <= 1'b0;
        end else if (adv) begin
          a_msb_q <= a_src[WIDTH-1];
          b_msb_q <= b_src[WIDTH-1];
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign out_sum   = g_stage[LAST].sum_q;
  assign out_carry = g_stage[LAST].c_q;
  assign out_ovf   = (g_stage[LAST].g_last.a_msb_q == g_stage[LAST].g_last.b_msb_q) &
                     (out_sum[WIDTH-1] != g_stage[LAST].g_last.a_msb_q);

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed literal vectors plus an
// arithmetic reference model compared on every output handshake.
module tb_pipelined_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a = '0;
  logic [WIDTH-1:0]  in_b = '0;
  logic              in_sub = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  out_sum;
  logic              out_carry;
  logic              out_ovf;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    int               acc;
  } exp_t;

  exp_t  exp_q[$];
  int    checks  = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    retired = 0;
  bit    strict_lat = 1'b0;
  bit    done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub);
    exp_t   r;
    longint sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r.s = a - b;
      r.c = (a >= b);
      sr  = sa - sb;
    end else begin
      r.s = a + b;
      r.c = (longint'(a) + longint'(b)) > 64'sd4294967295;
      sr  = sa + sb;
    end
    r.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.acc = 0;
    return r;
  endfunction

  // Compare process: sampled on the falling edge, between active edges.
  initial begin
    exp_t             e;
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_sum   = '0;
    logic             prev_c     = 1'b0;
    logic             prev_v     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        if (prev_stall) begin
          check("stall_valid", out_valid, 1'b1);
          check("stall_sum", out_sum, prev_sum);
          check("stall_carry", out_carry, prev_c);
          check("stall_ovf", out_ovf, prev_v);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", out_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("model_sum", out_sum, e.s);
            check("model_carry", out_carry, e.c);
            check("model_ovf", out_ovf, e.v);
            if (strict_lat) check("model_latency", cyc - e.acc, STAGES - 1);
            retired++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = out_sum;
        prev_c     = out_carry;
        prev_v     = out_ovf;
        if (in_valid && in_ready) begin
          e     = model(in_a, in_b, in_sub);
          e.acc = cyc + 1;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Driver phase: all input changes happen 2 time units after a rising edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    bit acc = 1'b0;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      if (acc) break;
    end
    check("send_accept", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic expect_one(input string name, input logic [WIDTH-1:0] s,
                            input logic c, input logic v);
    int got_n = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        got_n = n;
        break;
      end
    end
    check({name, "_latency"}, got_n, STAGES);
    check({name, "_sum"}, out_sum, s);
    check({name, "_carry"}, out_carry, c);
    check({name, "_ovf"}, out_ovf, v);
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name, input int want);
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #2;
    end
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_retired"}, retired, want);
  endtask

  initial begin
    int base;

    // Reset with in_valid held high: nothing may enter or emerge.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_a     = 32'h1234_5678;
    in_b     = 32'h0000_0001;
    repeat (2) begin
      @(posedge clk);
      #2;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_sum", out_sum, 32'h0);
      check("reset_out_carry", out_carry, 1'b0);
      check("reset_out_ovf", out_ovf, 1'b0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #2;

    // Directed vectors with hand-computed results.
    strict_lat = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    expect_one("add_wrap", 32'h0000_0000, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    expect_one("add_ovf", 32'h8000_0000, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    expect_one("add_negovf", 32'h0000_0000, 1'b1, 1'b1);
    send(32'h0000_0005, 32'h0000_0007, 1'b1);
    expect_one("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b1);
    expect_one("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1);
    send(32'h1234_5678, 32'h1234_5678, 1'b1);
    expect_one("sub_equal", 32'h0000_0000, 1'b1, 1'b0);
    drain("directed", 6);

    // Back-to-back stream: one result per cycle at fixed latency.
    base = retired;
    for (int i = 0; i < 100; i++) begin
      send($urandom, $urandom, 1'(($urandom_range(0, 1))));
    end
    drain("stream", base + 100);

    // Random back-pressure with random input gaps.
    strict_lat = 1'b0;
    base = retired;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #2;
          end
          send($urandom, $urandom, 1'(($urandom_range(0, 1))));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain("backpressure", base + 60);

    // Mid-flight reset: three sets in the pipe are discarded.
    strict_lat = 1'b1;
    base = retired;
    send(32'h0000_0011, 32'h0000_0022, 1'b0);
    send(32'h0000_0033, 32'h0000_0044, 1'b0);
    send(32'h0000_0055, 32'h0000_0066, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_no_result", out_valid, 1'b0);
    end
    @(posedge clk);
    #2;
    send(32'h0000_0010, 32'h0000_0020, 1'b1);
    expect_one("post_reset", 32'hFFFF_FFF0, 1'b0, 1'b0);
    drain("post_reset", base + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
